// File: rtl/ge_arb_pkg.sv
// Shared types and constants for the ge comparator arbiter.
// Tag pipeline entries, stat counter limits and id-width helper.
package ge_arb_pkg;

    localparam int STAT_W   = 16;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;
    localparam int ID_MAX_W = 3;

    // Wide enough for any legal N (2..8); narrower ids are zero-extended.
    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } tag_t;

    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ge_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          any
);

    int idx;

    // Walk from the farthest offset down so the nearest hit wins last.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_id   = IW'(idx);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ge_arbiter.sv
// Round-robin front end sharing one pipelined ge comparator among N requesters.
// Optional per-requester grant counters are built when GE_ARB_STATS_EN is defined.
module ge_arbiter
    import ge_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req_valid,
    output logic [N-1:0]       req_ready,
    input  logic [N*WIDTH-1:0] req_a,
    input  logic [N*WIDTH-1:0] req_b,
    output logic [N-1:0]       resp_valid,
    output logic               resp_z,
    output logic [WIDTH-1:0]   cmp_a,
    output logic [WIDTH-1:0]   cmp_b,
    input  logic               cmp_z
`ifdef GE_ARB_STATS_EN
    ,
    output logic [N*STAT_W-1:0] stat_cnt
`endif
);

    localparam int IW = id_w(N);

    logic [IW-1:0]      ptr;
    logic [N-1:0]       gnt;
    logic [IW-1:0]      gnt_id;
    logic               any;
    logic               xfer;
    tag_t [LATENCY:0]   tag_q;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req    (req_valid),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any)
    );

    assign req_ready = rst ? '0 : gnt;
    assign xfer      = any & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            cmp_a <= '0;
            cmp_b <= '0;
        end else if (xfer) begin
            ptr   <= (int'(gnt_id) == N - 1) ? '0 : gnt_id + 1'b1;
            cmp_a <= req_a[int'(gnt_id)*WIDTH +: WIDTH];
            cmp_b <= req_b[int'(gnt_id)*WIDTH +: WIDTH];
        end
    end

    // Tag shifts every cycle so its last stage lines up with cmp_z.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= xfer ? {1'b1, ID_MAX_W'(gnt_id)} : '0;
            for (int s = 1; s <= LATENCY; s++)
                tag_q[s] <= tag_q[s-1];
        end
    end

    always_comb begin
        resp_valid = '0;
        resp_z     = 1'b0;
        if (tag_q[LATENCY].valid) begin
            resp_valid[tag_q[LATENCY].id[IW-1:0]] = 1'b1;
            resp_z = cmp_z;
        end
    end

`ifdef GE_ARB_STATS_EN
    logic [N-1:0][STAT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (xfer && cnt[gnt_id] != STAT_MAX)
            cnt[gnt_id] <= cnt[gnt_id] + 1'b1;
    end

    assign stat_cnt = cnt;
`endif

endmodule

// File: tb/tb_ge_arbiter.sv
// Bench for ge_arbiter: directed scenarios then random traffic, scored by a grant/response model.
module tb_ge_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   resp_valid;
    logic           resp_z;
    logic [W-1:0]   cmp_a;
    logic [W-1:0]   cmp_b;
    logic           cmp_z = 1'b0;
`ifdef GE_ARB_STATS_EN
    logic [N*16-1:0] stat_cnt;
`endif

    always #5 clk = ~clk;

    // Single-cycle pipelined ge comparator sitting next to the arbiter.
    always @(posedge clk) cmp_z <= (cmp_a >= cmp_b);

    ge_arbiter #(.N(N), .WIDTH(W), .LATENCY(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_z     (resp_z),
        .cmp_a      (cmp_a),
        .cmp_b      (cmp_b),
        .cmp_z      (cmp_z)
`ifdef GE_ARB_STATS_EN
        ,
        .stat_cnt   (stat_cnt)
`endif
    );

    int passed = 0;
    int total  = 0;

    // Reference model: rotating priority index, two-deep expected-response queue.
    int           m_ptr = 0;
    logic [N-1:0] p0_v = '0, p1_v = '0;
    logic         p0_z = 1'b0, p1_z = 1'b0;
    logic [W-1:0] e_a = '0, e_b = '0;
    int           m_cnt [N];
    logic [W-1:0] av [N];
    logic [W-1:0] bv [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        av[i] = W'(a);
        bv[i] = W'(b);
    endtask

    // Called at a negedge: score last results, drive new inputs, score the grant.
    task automatic step(input logic r, input logic [N-1:0] v);
        int g;
        chk("resp_valid", 64'(resp_valid), 64'(p1_v));
        chk("resp_z", 64'(resp_z), 64'(p1_z));
        chk("cmp_a", 64'(cmp_a), 64'(e_a));
        chk("cmp_b", 64'(cmp_b), 64'(e_b));
        p1_v = p0_v;
        p1_z = p0_z;
        rst = r;
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = av[i];
            req_b[i*W +: W] = bv[i];
        end
        #1;
        g = -1;
        p0_v = '0;
        p0_z = 1'b0;
        if (r) begin
            p1_v = '0;
            p1_z = 1'b0;
            m_ptr = 0;
            e_a = '0;
            e_b = '0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else begin
            for (int k = 0; k < N; k++)
                if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            if (g >= 0) begin
                p0_v[g] = 1'b1;
                p0_z = (av[g] >= bv[g]);
                e_a = av[g];
                e_b = bv[g];
                m_ptr = (g + 1) % N;
                if (m_cnt[g] < 65535) m_cnt[g]++;
            end
        end
        chk("req_ready", 64'(req_ready), 64'(p0_v));
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            set_ops(i, 0, 0);
            m_cnt[i] = 0;
        end
        repeat (2) @(negedge clk);

        // Reset then idle.
        step(1'b1, '0);
        step(1'b1, '0);
        repeat (10) step(1'b0, '0);

        // Single request from requester 2, 7 >= 3.
        set_ops(2, 7, 3);
        step(1'b0, 4'b0100);
        repeat (3) step(1'b0, '0);

        // Pointer wrap: ptr is 3, requesters 0 and 3 both valid.
        set_ops(0, 5, 9);
        set_ops(3, 1, 1);
        step(1'b0, 4'b1001);
        step(1'b0, 4'b1001);
        repeat (3) step(1'b0, '0);

        // Full contention from a fresh pointer, a=i b=2.
        step(1'b1, '0);
        for (int i = 0; i < N; i++) set_ops(i, i, 2);
        repeat (8) step(1'b0, 4'b1111);
        repeat (3) step(1'b0, '0);

        // Reset while a request is in flight.
        step(1'b0, 4'b0010);
        step(1'b1, '0);
        repeat (3) step(1'b0, '0);
        step(1'b0, 4'b1111);
        repeat (2) step(1'b0, '0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) set_ops(i, $urandom_range(0, 15), $urandom_range(0, 15));
            step(($urandom_range(0, 39) == 0), N'($urandom));
        end
        repeat (3) step(1'b0, '0);

`ifdef GE_ARB_STATS_EN
        step(1'b1, '0);
        set_ops(0, 1, 2);
        repeat (65540) step(1'b0, 4'b0001);
        step(1'b0, '0);
        chk("stat_sat", 64'(stat_cnt[15:0]), 64'(16'hFFFF));
        for (int i = 0; i < N; i++)
            chk($sformatf("stat_cnt%0d", i), 64'(stat_cnt[i*16 +: 16]), 64'(m_cnt[i]));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
